// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq -- drives a PLL reconfiguration core through one full
// retune and then waits for the PLL to requalify lock.
//
// A request is accepted in IDLE (cfg_valid & cfg_ready). Every cfg_* word
// is latched. The block then streams the register writes back to back on
// the management bus, honouring mgmt_waitrequest, and ends with the START
// write. After that it waits for LOCK_QUAL consecutive synchronized-locked
// cycles (done pulse) or for LOCK_TIMEOUT cycles (timeout pulse). Either
// outcome spends one FINISH cycle before the block returns to IDLE.
//
// Write sequence (address:data):
//   0:0 (waitrequest mode), 3:N, 4:M, 5:{C index 0, C0}, 7:K,
//   [8:bw, 9:cp when PLL_RECONFIG_BWCP_EN is defined], 2:1 (START)
//
// Optional feature macro: PLL_RECONFIG_BWCP_EN adds the bandwidth and
// charge-pump writes. Without it, cfg_bw and cfg_cp are ignored.
//
// Ports:
//   clk, rst              management clock, synchronous active-high reset
//   cfg_valid/cfg_ready   request handshake (ready only in IDLE)
//   cfg_n/m/c0            18-bit counter words {odd, bypass, hi[7:0], lo[7:0]}
//   cfg_k                 32-bit fractional M value
//   cfg_bw, cfg_cp        bandwidth / charge-pump settings
//   mgmt_*                reconfig-core write port (waitrequest style)
//   pll_locked            asynchronous lock from the PLL
//   busy, done, timeout   status; done and timeout are one-cycle pulses
`timescale 1ns/1ps
module pll_reconfig_seq #(
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned LOCK_QUAL    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    input  logic [3:0]  cfg_bw,
    input  logic [2:0]  cfg_cp,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        timeout
);
    localparam int unsigned QW = $clog2(LOCK_QUAL + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    // Compare against the value one below the limit, so the transition fires
    // on the same edge where the counter would reach the limit.
    localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_QUAL - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
`ifdef PLL_RECONFIG_BWCP_EN
    localparam logic [2:0] LAST_WR = 3'd7;
`else
    localparam logic [2:0] LAST_WR = 3'd5;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_LOCK, S_FINISH} state_e;

    state_e          state_q, state_d;
    logic [2:0]      wr_idx_q, wr_idx_d;
    logic [QW-1:0]   qual_q, qual_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      sync_q;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic [17:0]     n_q, m_q, c0_q;
    logic [31:0]     k_q;
    logic            accept;
`ifdef PLL_RECONFIG_BWCP_EN
    logic [3:0]      bw_q;
    logic [2:0]      cp_q;
`else
    logic            unused_bwcp;
    assign unused_bwcp = ^{cfg_bw, cfg_cp};
`endif

    assign accept    = cfg_valid && (state_q == S_IDLE);
    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_idx_q  <= '0;
            qual_q    <= '0;
            tmo_q     <= '0;
            sync_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            n_q       <= '0;
            m_q       <= '0;
            c0_q      <= '0;
            k_q       <= '0;
`ifdef PLL_RECONFIG_BWCP_EN
            bw_q      <= '0;
            cp_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            qual_q    <= qual_d;
            tmo_q     <= tmo_d;
            sync_q    <= {sync_q[0], pll_locked};
            done_q    <= done_d;
            timeout_q <= timeout_d;
            if (accept) begin
                n_q  <= cfg_n;
                m_q  <= cfg_m;
                c0_q <= cfg_c0;
                k_q  <= cfg_k;
`ifdef PLL_RECONFIG_BWCP_EN
                bw_q <= cfg_bw;
                cp_q <= cfg_cp;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        qual_d    = qual_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_d  = S_WRITE;
                    wr_idx_d = '0;
                end
            end
            S_WRITE: begin
                if (!mgmt_waitrequest) begin
                    if (wr_idx_q == LAST_WR) begin
                        state_d = S_WAIT_LOCK;
                        qual_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + 3'd1;
                    end
                end
            end
            S_WAIT_LOCK: begin
                qual_d = sync_q[1] ? qual_q + QW'(1) : '0;
                tmo_d  = tmo_q + TW'(1);
                // Qualification is checked first so it wins a tie with timeout.
                if (sync_q[1] && (qual_q == QUAL_LAST)) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Write port is a pure decode of the registered index, so it stays
    // stable for as long as waitrequest holds the index still.
    always_comb begin
        mgmt_write     = (state_q == S_WRITE);
        mgmt_address   = '0;
        mgmt_writedata = '0;
        if (state_q == S_WRITE) begin
            case (wr_idx_q)
                3'd0: begin mgmt_address = 6'd0; mgmt_writedata = 32'd0;                   end
                3'd1: begin mgmt_address = 6'd3; mgmt_writedata = {14'd0, n_q};            end
                3'd2: begin mgmt_address = 6'd4; mgmt_writedata = {14'd0, m_q};            end
                3'd3: begin mgmt_address = 6'd5; mgmt_writedata = {9'd0, 5'd0, c0_q};      end
                3'd4: begin mgmt_address = 6'd7; mgmt_writedata = k_q;                     end
`ifdef PLL_RECONFIG_BWCP_EN
                3'd5: begin mgmt_address = 6'd8; mgmt_writedata = {28'd0, bw_q};           end
                3'd6: begin mgmt_address = 6'd9; mgmt_writedata = {29'd0, cp_q};           end
                3'd7: begin mgmt_address = 6'd2; mgmt_writedata = 32'd1;                   end
`else
                3'd5: begin mgmt_address = 6'd2; mgmt_writedata = 32'd1;                   end
`endif
                default: begin mgmt_address = 6'd0; mgmt_writedata = 32'd0;               end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
`timescale 1ns/1ps
module tb_pll_reconfig_seq;
    localparam int LT = 100;
    localparam int LQ = 16;
`ifdef PLL_RECONFIG_BWCP_EN
    localparam int NW = 8;
`else
    localparam int NW = 6;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0;
    logic [31:0] cfg_k = '0;
    logic [3:0]  cfg_bw = '0;
    logic [2:0]  cfg_cp = '0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic        busy, done, timeout;

    pll_reconfig_seq #(.LOCK_TIMEOUT(LT), .LOCK_QUAL(LQ)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_k(cfg_k),
        .cfg_bw(cfg_bw), .cfg_cp(cfg_cp), .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    logic [37:0] sb[$];   // {address, data} in expected issue order

    int start_cnt = 0, start_edge = 0;
    int done_cnt = 0, done_cyc = 0;
    int tmo_cnt = 0, tmo_cyc = 0;
    int m_vis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                            input logic [31:0] k, input logic [3:0] bw, input logic [2:0] cp);
        sb.push_back({6'd0, 32'd0});
        sb.push_back({6'd3, 14'd0, n});
        sb.push_back({6'd4, 14'd0, m});
        sb.push_back({6'd5, 9'd0, 5'd0, c0});
        sb.push_back({6'd7, k});
`ifdef PLL_RECONFIG_BWCP_EN
        sb.push_back({6'd8, 28'd0, bw});
        sb.push_back({6'd9, 29'd0, cp});
`endif
        sb.push_back({6'd2, 32'd1});
    endtask

    // Returns the edge index at which the request was accepted.
    task automatic send(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                        input logic [31:0] k, input logic [3:0] bw, input logic [2:0] cp,
                        output int acc);
        int g = 0;
        while (!cfg_ready && g < 300) begin tick(1); g++; end
        chk("ready_before_send", cfg_ready, 1);
        cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_k = k; cfg_bw = bw; cfg_cp = cp;
        cfg_valid = 1'b1;
        push_exp(n, m, c0, k, bw, cp);
        tick(1);
        acc = cyc;
        cfg_valid = 1'b0;
        // Scramble inputs: the DUT must use its latched copy.
        cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_c0 = 18'($urandom);
        cfg_k = $urandom; cfg_bw = 4'($urandom); cfg_cp = 3'($urandom);
    endtask

    task automatic wait_start(output int e0);
        int s0 = start_cnt;
        int g = 0;
        while (start_cnt == s0 && g < 100) begin tick(1); g++; end
        chk("start_seen", start_cnt != s0, 1);
        e0 = start_edge;
    endtask

    task automatic wait_fin(input int bound);
        int s0 = done_cnt + tmo_cnt;
        int g = 0;
        while (done_cnt + tmo_cnt == s0 && g < bound) begin tick(1); g++; end
        chk("finish_seen", (done_cnt + tmo_cnt) != s0, 1);
    endtask

    // Bus monitor: pops the scoreboard on each completed write and checks
    // that a stalled write holds its address/data.
    initial begin
        logic        prev_stall = 1'b0;
        logic [5:0]  prev_addr = '0;
        logic [31:0] prev_data = '0;
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_write", mgmt_write, 1);
                chk("stall_addr", mgmt_address, prev_addr);
                chk("stall_data", mgmt_writedata, prev_data);
            end
            if (mgmt_write && !mgmt_waitrequest) begin
                chk("sb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", mgmt_address, e[37:32]);
                    chk("wr_data", mgmt_writedata, e[31:0]);
                end
                if (mgmt_address == 6'd2) begin
                    start_edge = cyc + 1;
                    start_cnt++;
                end
            end
            if (mgmt_write && mgmt_address == 6'd4) m_vis++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (timeout) begin tmo_cnt++; tmo_cyc = cyc; end
            if (done || timeout) chk("done_and_timeout", done && timeout, 0);
            prev_stall = mgmt_write && mgmt_waitrequest;
            prev_addr  = mgmt_address;
            prev_data  = mgmt_writedata;
        end
    end

    initial begin
        int a, e0, d0, t0, m0, r;

        // Reset state
        tick(3);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_data", mgmt_writedata, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick(2);

        // Nominal retune, lock rises after START
        d0 = done_cnt; t0 = tmo_cnt;
        send(18'h10000, 18'h00404, 18'h20302, 32'h45B056F5, 4'h6, 3'h3, a);
        chk("busy_in_write", busy, 1);
        chk("ready_in_write", cfg_ready, 0);
        wait_start(e0);
        chk("t1_back_to_back", e0 - a, NW);
        pll_locked = 1'b1;
        wait_fin(200);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_no_timeout", tmo_cnt - t0, 0);
        chk("t1_done_latency", done_cyc - e0, LQ + 2);
        chk("t1_idle_ready", cfg_ready, 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Waitrequest stall on the M write; lock already qualified
        d0 = done_cnt; m0 = m_vis;
        send(18'h3_0A0B, 18'h0_1234, 18'h1_FFEE, 32'hDEAD_BEEF, 4'h9, 3'h5, a);
        tick(2);
        mgmt_waitrequest = 1'b1;
        chk("t2_stall_addr", mgmt_address, 4);
        tick(3);
        mgmt_waitrequest = 1'b0;
        wait_start(e0);
        chk("t2_m_visible", m_vis - m0, 4);
        chk("t2_start_edge", e0 - a, NW + 3);
        wait_fin(200);
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_done_latency", done_cyc - e0, LQ);

        // Lock stuck low -> timeout
        pll_locked = 1'b0;
        d0 = done_cnt; t0 = tmo_cnt;
        send(18'h0_0101, 18'h2_0808, 18'h0_0505, 32'h0000_0001, 4'h1, 3'h1, a);
        wait_start(e0);
        wait_fin(300);
        chk("t3_timeout_cnt", tmo_cnt - t0, 1);
        chk("t3_no_done", done_cnt - d0, 0);
        chk("t3_timeout_latency", tmo_cyc - e0, LT);
        chk("t3_ready_next", cfg_ready, 1);

        // Reset during the K write, then a clean restart
        pll_locked = 1'b1;
        d0 = done_cnt; t0 = tmo_cnt;
        send(18'h1_1111, 18'h2_2222, 18'h3_3333, 32'h1234_5678, 4'h2, 3'h2, a);
        begin
            int g = 0;
            while (mgmt_address != 6'd7 && g < 20) begin tick(1); g++; end
        end
        chk("t4_at_k", mgmt_address, 7);
        rst = 1'b1;
        tick(1);
        chk("t4_rst_write", mgmt_write, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ready", cfg_ready, 1);
        chk("t4_rst_addr", mgmt_address, 0);
        chk("t4_sb_left", sb.size(), 1);
        sb.delete();
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_timeout", tmo_cnt - t0, 0);
        send(18'h0_00AA, 18'h0_00BB, 18'h0_00CC, 32'hCAFE_F00D, 4'hF, 3'h7, a);
        wait_start(e0);
        chk("t4_restart_len", e0 - a, NW);
        wait_fin(200);
        chk("t4_restart_done", done_cnt - d0, 1);

        // Lock glitch before steady lock; cfg_valid while busy is ignored
        pll_locked = 1'b0;
        tick(3);
        d0 = done_cnt;
        send(18'h2_5A5A, 18'h1_A5A5, 18'h0_0F0F, 32'h8000_0000, 4'h4, 3'h6, a);
        cfg_valid = 1'b1;
        cfg_n = 18'h3_FFFF;
        tick(1);
        cfg_valid = 1'b0;
        wait_start(e0);
        pll_locked = 1'b1;
        tick(3);
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        r = cyc + 1;
        wait_fin(200);
        chk("t5_done_cnt", done_cnt - d0, 1);
        chk("t5_done_latency", done_cyc - r, LQ + 1);
        tick(3);
        chk("t5_no_extra_writes", sb.size(), 0);
        chk("t5_idle", cfg_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
